// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator (binary up/down, Gray, bounce)
module led_pattern_gen #(
  parameter int WIDTH      = 6,
  parameter int WAIT_TIME  = 5000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             step,
  output logic [WIDTH-1:0] led,
  output logic             tick
);
  localparam int PW = $clog2(WAIT_TIME);
  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(WAIT_TIME - 1);
  localparam logic [SW-1:0] TOP = SW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MASK = (ACTIVE_LOW != 0) ? '1 : '0;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, led_q, pat_d;
  logic [SW-1:0]    pos_q, pos_d, pos_n;
  logic [1:0]       mode_q;
  logic             dir_q, dir_d, dir_n, tick_q, chg, adv, bounce;
  // mode change clears all state and suppresses any advance in that cycle
  always_comb begin
    chg     = mode != mode_q;
    adv     = !chg && (enable ? presc_q == LAST : step);
    bounce  = mode == 2'b11;
    presc_d = chg ? '0 : !enable ? presc_q : (presc_q == LAST) ? '0 : presc_q + PW'(1);
    pos_n   = (WIDTH == 1) ? '0 : dir_q ? pos_q - SW'(1) : pos_q + SW'(1);
    dir_n   = ((!dir_q && pos_n == TOP) || (dir_q && pos_n == '0)) ? ~dir_q : dir_q;
    cnt_d   = chg ? '0 : (!adv || bounce) ? cnt_q : (mode == 2'b01) ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
    pos_d   = chg ? '0 : (adv && bounce) ? pos_n : pos_q;
    dir_d   = chg ? 1'b0 : (adv && bounce) ? dir_n : dir_q;
    pat_d   = bounce ? WIDTH'(1) << pos_d : (mode == 2'b10) ? cnt_d ^ (cnt_d >> 1) : cnt_d;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      mode_q  <= mode;
      led_q   <= MASK;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      tick_q  <= adv;
      mode_q  <= mode;
      led_q   <= pat_d ^ MASK;
    end
  end
  assign led  = led_q;
  assign tick = tick_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: randomized scoreboard bench with an arithmetic reference model
module tb_led_pattern_gen;
  localparam int W = 4;
  localparam int WT = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic step = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] led;
  logic tick;
  int nchecks = 0;
  int nerr = 0;
  logic [W:0] exp_q[$];
  logic [W-1:0] tick_leds[$];
  int m_presc, m_k;
  logic [1:0] m_mode;

  led_pattern_gen #(.WIDTH(W), .WAIT_TIME(WT), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .step(step), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  // pattern after k advances since the last clear, straight from the mode rules
  function automatic logic [W-1:0] pat(input logic [1:0] m, input int k);
    logic [W-1:0] g;
    int p;
    g = W'(k % (1 << W));
    if (m == 2'b00) return g;
    if (m == 2'b01) return W'(((1 << W) - k % (1 << W)) % (1 << W));
    if (m == 2'b10) return g ^ (g >> 1);
    p = k % (2 * (W - 1));
    p = (p < W) ? p : 2 * (W - 1) - p;
    return W'(1 << p);
  endfunction

  task automatic cyc(input logic e, input logic s, input logic [1:0] m, input logic r);
    logic et;
    logic [W-1:0] el;
    @(negedge clk);
    enable = e; step = s; mode = m; reset = r;
    if (r) begin
      m_presc = 0; m_k = 0; m_mode = m; et = 1'b0; el = '1;
    end else if (m != m_mode) begin
      m_presc = 0; m_k = 0; m_mode = m; et = 1'b0; el = ~pat(m, 0);
    end else begin
      et = e ? (m_presc == WT - 1) : s;
      if (e) m_presc = (m_presc + 1) % WT;
      if (et) m_k++;
      el = ~pat(m_mode, m_k);
    end
    exp_q.push_back({et, el});
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    logic [W:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nchecks++;
        if ({tick, led} !== e) begin
          nerr++;
          $display("FAIL scoreboard @%0t: tick/led got %b/%b expected %b/%b", $time, tick, led, e[W], e[W-1:0]);
        end
        if (tick) tick_leds.push_back(led);
      end
    end
  end

  initial begin : stim
    logic [W-1:0] exp_b[8];
    int guard;
    cyc(0, 0, 2'b00, 1);
    cyc(0, 0, 2'b00, 1);
    drain();
    chk("reset_led", led, 4'hF);
    chk("reset_tick", {3'b0, tick}, 4'h0);
    for (int i = 0; i < 72; i++) cyc(1, 0, 2'b00, 0);
    cyc(0, 0, 2'b01, 1);
    tick_leds.delete();
    for (int i = 0; i < 8; i++) cyc(1, 0, 2'b01, 0);
    drain();
    chk("down_cnt", W'(tick_leds.size()), 4'd2);
    if (tick_leds.size() >= 2) begin
      chk("down_t0", tick_leds[0], 4'b0000);
      chk("down_t1", tick_leds[1], 4'b0001);
    end
    cyc(0, 0, 2'b10, 1);
    tick_leds.delete();
    for (int i = 0; i < 16; i++) cyc(1, 0, 2'b10, 0);
    drain();
    chk("gray_cnt", W'(tick_leds.size()), 4'd4);
    if (tick_leds.size() >= 4) begin
      chk("gray_t0", tick_leds[0], 4'b1110);
      chk("gray_t1", tick_leds[1], 4'b1100);
      chk("gray_t2", tick_leds[2], 4'b1101);
      chk("gray_t3", tick_leds[3], 4'b1001);
    end
    cyc(0, 0, 2'b11, 1);
    tick_leds.delete();
    for (int i = 0; i < 32; i++) cyc(1, 0, 2'b11, 0);
    drain();
    exp_b = '{4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011};
    chk("bounce_cnt", W'(tick_leds.size()), 4'd8);
    if (tick_leds.size() >= 8)
      for (int i = 0; i < 8; i++) chk($sformatf("bounce_t%0d", i), tick_leds[i], exp_b[i]);
    cyc(0, 0, 2'b00, 1);
    cyc(1, 0, 2'b00, 0);
    cyc(1, 0, 2'b00, 0);
    tick_leds.delete();
    for (int i = 0; i < 10; i++) cyc(0, 0, 2'b00, 0);
    cyc(0, 1, 2'b00, 0);
    cyc(0, 0, 2'b00, 0);
    cyc(1, 0, 2'b00, 0);
    cyc(1, 0, 2'b00, 0);
    drain();
    chk("hold_step_ticks", W'(tick_leds.size()), 4'd2);
    guard = 0;
    while (m_presc != WT - 1 && guard < 8) begin
      cyc(1, 0, 2'b00, 0);
      guard++;
    end
    cyc(1, 0, 2'b11, 0);
    drain();
    chk("modechg_led", led, 4'b1110);
    chk("modechg_tick", {3'b0, tick}, 4'h0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 2'b11, 0);
    cyc(1, 1, 2'b10, 1);
    drain();
    chk("midsweep_rst_led", led, 4'hF);
    chk("midsweep_rst_tick", {3'b0, tick}, 4'h0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
          ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : m_mode,
          $urandom_range(0, 63) == 0);
    drain();
    drain();
    nchecks++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
